ftrace_unit: RTL
================

FTRACE_UNIT -- requirements
Module: ftrace_unit

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 16, meaning shadow call-stack entries (power of 2, >=2).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning event-queue entries (power of 2, >=2).
REQ-003 SHALL have parameter DW = $clog2(STACK_DEPTH+1), meaning the width of depth fields.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 commit_valid  in  1  one instruction retires this cycle.
REQ-007 commit_inst  in  32  retired RV32 instruction word.
REQ-008 commit_pc  in  32  PC of the retired instruction.
REQ-009 commit_dnpc  in  32  next PC actually taken.
REQ-010 ev_valid  out  1  event record available at the queue head.
REQ-011 ev_ready  in  1  consumer accepts the head record when ev_valid=1.
REQ-012 ev_type  out  2  head record type: 0=CALL, 1=RET, 2=JUMP.
REQ-013 ev_pc / ev_target  out  32 each  head record commit_pc / commit_dnpc.
REQ-014 ev_depth  out  DW  head record stack depth after the operation.
REQ-015 ev_flags  out  3  head record flags: [0] ret mismatch, [1] underflow, [2] overflow.
REQ-016 cur_depth  out  DW  live shadow-stack occupancy.
REQ-017 drop_cnt  out  16  number of events lost to a full queue; saturates at 0xFFFF.

Function
REQ-018 Instructions SHALL be classified only while commit_valid=1, in this priority order:
- RET: inst==32'h00008067.
- CALL: opcode 1101111 with rd==1, or opcode 1100111 with funct3==0 and rd==1.
- JUMP: opcode 1100111, funct3==0, rd==0, imm[11:0]==0.
- Otherwise: no event and no state change.
REQ-019 CALL SHALL push commit_pc+4 (mod 2^32) onto the shadow stack and increment depth.
REQ-020 CALL at depth==STACK_DEPTH SHALL overwrite the oldest entry (circular) and keep depth at STACK_DEPTH.
- Its record SHALL carry flags[2]=1.
REQ-021 RET at depth>0 SHALL pop the top entry and decrement depth.
- flags[0]=1 iff the popped address != commit_dnpc.
REQ-022 RET at depth==0 SHALL leave the stack unchanged and set flags[1]=1 (flags[0]=0).
REQ-023 JUMP SHALL not modify the stack; its record carries the current depth and flags=0.
REQ-024 Stack updates SHALL occur at the edge that samples the commit, independent of queue state.
REQ-025 Each classified commit SHALL produce one record written into the queue at that same edge.
REQ-026 Latency: a record written to an empty queue SHALL appear with ev_valid=1 in the next cycle.
REQ-027 Queue order SHALL be FIFO; a record is dequeued at an edge where ev_valid && ev_ready.
REQ-028 ev_* fields SHALL hold stable while ev_valid=1 && ev_ready=0.
REQ-029 If the queue is full and no dequeue occurs that edge, the new record SHALL be dropped and drop_cnt incremented (saturating).
REQ-030 If the queue is full and a dequeue occurs that edge, the new record SHALL be accepted; nothing is dropped.
REQ-031 Read/write pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be distinguished by an extra pointer bit or a counter.
REQ-032 cur_depth SHALL reflect the stack update one cycle after the commit edge.

Reset
REQ-033 rst_n=0 SHALL immediately clear:
- depth, both queue pointers and drop_cnt;
- ev_valid=0, cur_depth=0, drop_cnt=0.
REQ-034 Stack and queue storage contents need not be reset; ev_type/ev_pc/ev_target/ev_depth/ev_flags SHALL read 0 while ev_valid=0.
REQ-035 Reset asserted mid-stream SHALL discard all pending records and stack contents; the first commit after release SHALL be treated as being at depth 0.

Verification
REQ-036 Bench SHALL cover:
- Nested call/return: CALL jal x1 at pc 0x80000000, then RET with dnpc 0x80000004 -> records CALL (depth 1, flags 0), then RET (depth 0, flags 0).
- Return mismatch: CALL at 0x100, then RET with dnpc 0x200 -> RET record flags=3'b001, depth 0.
- Underflow: RET at depth 0 -> flags=3'b010, depth 0, cur_depth stays 0.
- Stack overflow: STACK_DEPTH+1 consecutive CALLs -> last record flags=3'b100, depth=STACK_DEPTH; then STACK_DEPTH matching RETs -> all flags 0, final depth 0.
- Queue backpressure, ev_ready=0:
  - FIFO_DEPTH+3 JUMPs -> drop_cnt=3, and the queue holds the first FIFO_DEPTH records in order.
  - When full with ev_ready=1 plus a commit the same cycle -> drop_cnt unchanged.
- Async reset: assert rst_n=0 mid-burst without a clock edge -> ev_valid=0, cur_depth=0, drop_cnt=0 immediately.

Source files
------------

// File: rtl/ftrace_unit.sv
`default_nettype none
// ============================================================================
//  Module   : ftrace_unit
//  Function : Shadow call-stack tracer. It classifies retired CALL/RET/JUMP
//             instructions and queues one event record for each of them.
//  Revision : 1.0
// ============================================================================
module ftrace_unit #(
    parameter int STACK_DEPTH = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int DW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          commit_valid,
    input  logic [31:0]   commit_inst,
    input  logic [31:0]   commit_pc,
    input  logic [31:0]   commit_dnpc,
    output logic          ev_valid,
    input  logic          ev_ready,
    output logic [1:0]    ev_type,
    output logic [31:0]   ev_pc,
    output logic [31:0]   ev_target,
    output logic [DW-1:0] ev_depth,
    output logic [2:0]    ev_flags,
    output logic [DW-1:0] cur_depth,
    output logic [15:0]   drop_cnt
);

    localparam int          c_saw         = $clog2(STACK_DEPTH);
    localparam int          c_faw         = $clog2(FIFO_DEPTH);
    localparam int          c_rw          = 2 + 32 + 32 + DW + 3;
    localparam logic [1:0]  c_ev_call     = 2'd0;
    localparam logic [1:0]  c_ev_ret      = 2'd1;
    localparam logic [1:0]  c_ev_jump     = 2'd2;
    localparam logic [6:0]  c_op_jal      = 7'b1101111;
    localparam logic [6:0]  c_op_jalr     = 7'b1100111;
    localparam logic [31:0] c_ret_inst    = 32'h0000_8067;
    localparam logic [DW-1:0] c_stack_full = DW'(STACK_DEPTH);

    // ------------------------------------------------------------------
    // Instruction classification
    // ------------------------------------------------------------------
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [2:0]  w_funct3;
    logic [11:0] w_imm;
    logic        w_is_ret;
    logic        w_is_call;
    logic        w_is_jump;
    logic        w_event;

    assign w_opcode = commit_inst[6:0];
    assign w_rd     = commit_inst[11:7];
    assign w_funct3 = commit_inst[14:12];
    assign w_imm    = commit_inst[31:20];

    assign w_is_ret  = commit_valid && (commit_inst == c_ret_inst);
    assign w_is_call = commit_valid && !w_is_ret && (w_rd == 5'd1) &&
                       ((w_opcode == c_op_jal) ||
                        ((w_opcode == c_op_jalr) && (w_funct3 == 3'd0)));
    assign w_is_jump = commit_valid && !w_is_ret && !w_is_call &&
                       (w_opcode == c_op_jalr) && (w_funct3 == 3'd0) &&
                       (w_rd == 5'd0) && (w_imm == 12'd0);
    assign w_event   = w_is_ret || w_is_call || w_is_jump;

    // ------------------------------------------------------------------
    // Shadow stack: circular buffer, r_top points at the next free slot so
    // a push at full depth lands on the oldest entry.
    // ------------------------------------------------------------------
    logic [31:0]      r_stack [STACK_DEPTH];
    logic [c_saw-1:0] r_top;
    logic [DW-1:0]    r_depth;
    logic [c_saw-1:0] w_top_m1;
    logic [31:0]      w_pop_addr;
    logic [c_saw-1:0] w_top_next;
    logic [DW-1:0]    w_depth_next;
    logic             w_push;
    logic [1:0]       w_rec_type;
    logic [2:0]       w_rec_flags;

    assign w_top_m1   = r_top - 1'b1;
    assign w_pop_addr = r_stack[w_top_m1];

    always_comb begin
        w_top_next   = r_top;
        w_depth_next = r_depth;
        w_push       = 1'b0;
        w_rec_type   = c_ev_jump;
        w_rec_flags  = 3'b000;
        if (w_is_call) begin
            w_rec_type = c_ev_call;
            w_push     = 1'b1;
            w_top_next = r_top + 1'b1;
            if (r_depth == c_stack_full) begin
                w_rec_flags[2] = 1'b1;
            end else begin
                w_depth_next = r_depth + 1'b1;
            end
        end else if (w_is_ret) begin
            w_rec_type = c_ev_ret;
            if (r_depth == '0) begin
                w_rec_flags[1] = 1'b1;
            end else begin
                w_depth_next   = r_depth - 1'b1;
                w_top_next     = w_top_m1;
                w_rec_flags[0] = (w_pop_addr != commit_dnpc);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_top   <= '0;
            r_depth <= '0;
        end else begin
            r_top   <= w_top_next;
            r_depth <= w_depth_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[r_top] <= commit_pc + 32'd4;
        end
    end

    assign cur_depth = r_depth;

    // ------------------------------------------------------------------
    // Event queue: pointers carry one extra wrap bit to tell full from empty.
    // ------------------------------------------------------------------
    logic [c_rw-1:0]  r_fifo [FIFO_DEPTH];
    logic [c_faw:0]   r_wptr;
    logic [c_faw:0]   r_rptr;
    logic [15:0]      r_drop;
    logic             w_empty;
    logic             w_full;
    logic             w_deq;
    logic             w_enq;
    logic             w_drop;
    logic [c_rw-1:0]  w_record;
    logic [c_rw-1:0]  w_head;

    assign w_record = {w_rec_type, commit_pc, commit_dnpc, w_depth_next, w_rec_flags};
    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = (r_wptr[c_faw] != r_rptr[c_faw]) &&
                      (r_wptr[c_faw-1:0] == r_rptr[c_faw-1:0]);
    assign w_deq    = !w_empty && ev_ready;
    // A full queue still takes the new record when the head leaves this edge.
    assign w_enq    = w_event && (!w_full || w_deq);
    assign w_drop   = w_event && w_full && !w_deq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_drop <= '0;
        end else begin
            if (w_enq) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_deq) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_drop && (r_drop != 16'hFFFF)) begin
                r_drop <= r_drop + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_fifo[r_wptr[c_faw-1:0]] <= w_record;
        end
    end

    assign w_head    = r_fifo[r_rptr[c_faw-1:0]];
    assign ev_valid  = !w_empty;
    assign ev_type   = ev_valid ? w_head[c_rw-1 -: 2]       : 2'd0;
    assign ev_pc     = ev_valid ? w_head[c_rw-3 -: 32]      : 32'd0;
    assign ev_target = ev_valid ? w_head[c_rw-35 -: 32]     : 32'd0;
    assign ev_depth  = ev_valid ? w_head[DW+2 : 3]          : '0;
    assign ev_flags  = ev_valid ? w_head[2:0]               : 3'd0;
    assign drop_cnt  = r_drop;

endmodule
`default_nettype wire
